rect_hit_encoder: RTL and testbench

Per-pixel hit-test front end of the rectangle GPU. Compares the current raster coordinate against 64 rectangle bounding boxes in parallel, one comparator per rectangle, and reduces the 64 hit flags to the index of the winning rectangle through a 64-input priority encoder. Sits between the rectangle register file, which holds the bounds, and the colour-lookup / output stage, which consumes `rect_idx` and `hit`. It contains the comparator array and the priority encoder as its two pipelined sub-units.

---
 rtl/rect_hit_encoder.sv | 100 ++++++++++
 tb/tb_rect_hit_encoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rect_hit_encoder.sv
// Per-pixel hit test: 64 parallel bounding-box comparators feeding a
// highest-index-wins priority encoder, pipelined over three pixel clock edges.
module rect_hit_encoder #(
    parameter int COORD_WIDTH      = 16,
    parameter int RECT_COUNT       = 64,
    parameter int RECT_COUNT_WIDTH = 6
) (
    input  logic                              pixel_clk,
    input  logic                              reset_n,
    input  logic [COORD_WIDTH-1:0]            coord_x,
    input  logic [COORD_WIDTH-1:0]            coord_y,
    input  logic [RECT_COUNT*COORD_WIDTH-1:0] rect_left,
    input  logic [RECT_COUNT*COORD_WIDTH-1:0] rect_top,
    input  logic [RECT_COUNT*COORD_WIDTH-1:0] rect_right,
    input  logic [RECT_COUNT*COORD_WIDTH-1:0] rect_bottom,
    output logic [RECT_COUNT-1:0]             collisions,
    output logic                              hit,
    output logic [RECT_COUNT_WIDTH-1:0]       rect_idx
);

    logic [RECT_COUNT-1:0] x_ge_left;
    logic [RECT_COUNT-1:0] x_lt_right;
    logic [RECT_COUNT-1:0] y_ge_top;
    logic [RECT_COUNT-1:0] y_lt_bottom;

    // Inverted or empty rects fail one of the two half-open tests on their own.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_ge_left   <= '0;
            x_lt_right  <= '0;
            y_ge_top    <= '0;
            y_lt_bottom <= '0;
        end else begin
            for (int i = 0; i < RECT_COUNT; i++) begin
                x_ge_left[i]   <= coord_x >= rect_left[i*COORD_WIDTH +: COORD_WIDTH];
                x_lt_right[i]  <= coord_x <  rect_right[i*COORD_WIDTH +: COORD_WIDTH];
                y_ge_top[i]    <= coord_y >= rect_top[i*COORD_WIDTH +: COORD_WIDTH];
                y_lt_bottom[i] <= coord_y <  rect_bottom[i*COORD_WIDTH +: COORD_WIDTH];
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            collisions <= '0;
        end else begin
            collisions <= x_ge_left & x_lt_right & y_ge_top & y_lt_bottom;
        end
    end

    function automatic logic [1:0] top_of_four(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    logic [15:0] l1_valid;
    logic [1:0]  l1_idx [16];
    logic [3:0]  l2_valid;
    logic [1:0]  l2_sel [4];
    logic [3:0]  l2_idx [4];
    logic [1:0]  l3_sel;
    logic [5:0]  enc_idx;
    logic        enc_hit;

    // Three levels of 4:1 highest-index selection; an empty group reports
    // index 0, so no collision at all naturally encodes to 0.
    always_comb begin
        for (int g = 0; g < 16; g++) begin
            l1_valid[g] = |collisions[4*g +: 4];
            l1_idx[g]   = top_of_four(collisions[4*g +: 4]);
        end
    end

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            l2_valid[g] = |l1_valid[4*g +: 4];
            l2_sel[g]   = top_of_four(l1_valid[4*g +: 4]);
            l2_idx[g]   = {l2_sel[g], l1_idx[4*g + int'(l2_sel[g])]};
        end
    end

    always_comb begin
        l3_sel  = top_of_four(l2_valid);
        enc_hit = |l2_valid;
        enc_idx = {l3_sel, l2_idx[l3_sel]};
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            hit      <= 1'b0;
            rect_idx <= '0;
        end else begin
            hit      <= enc_hit;
            rect_idx <= enc_idx;
        end
    end

endmodule

// File: tb/tb_rect_hit_encoder.sv
// Directed bench for rect_hit_encoder: a vector table of single-pixel hit
// tests plus hand-written streaming and mid-stream reset sequences.
module tb_rect_hit_encoder;

    localparam int W = 16;
    localparam int N = 64;

    logic            pixel_clk;
    logic            reset_n;
    logic [W-1:0]    coord_x;
    logic [W-1:0]    coord_y;
    logic [N*W-1:0]  rect_left;
    logic [N*W-1:0]  rect_top;
    logic [N*W-1:0]  rect_right;
    logic [N*W-1:0]  rect_bottom;
    logic [N-1:0]    collisions;
    logic            hit;
    logic [5:0]      rect_idx;

    rect_hit_encoder #(.COORD_WIDTH(W), .RECT_COUNT(N), .RECT_COUNT_WIDTH(6)) dut (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .coord_x     (coord_x),
        .coord_y     (coord_y),
        .rect_left   (rect_left),
        .rect_top    (rect_top),
        .rect_right  (rect_right),
        .rect_bottom (rect_bottom),
        .collisions  (collisions),
        .hit         (hit),
        .rect_idx    (rect_idx)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic [63:0]  mask;
        logic [W-1:0] l, t, r, b, x, y;
        logic         exp_hit;
        logic [5:0]   exp_idx;
        logic [63:0]  exp_coll;
    } vec_t;

    vec_t vecs[20];
    int   n_vectors    = 0;
    int   n_miscompares = 0;

    function automatic vec_t mk(input logic [63:0] mask, input int l, input int t, input int r,
                                input int b, input int x, input int y, input logic eh,
                                input int ei, input logic [63:0] ec);
        vec_t v;
        v.mask = mask;
        v.l = W'(l); v.t = W'(t); v.r = W'(r); v.b = W'(b);
        v.x = W'(x); v.y = W'(y);
        v.exp_hit = eh; v.exp_idx = 6'(ei); v.exp_coll = ec;
        return v;
    endfunction

    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    // Rects selected by mask get the given box; all others are zero-area.
    task automatic applyStimulus(input vec_t v);
        for (int i = 0; i < N; i++) begin
            rect_left[i*W +: W]   = v.mask[i] ? v.l : '0;
            rect_top[i*W +: W]    = v.mask[i] ? v.t : '0;
            rect_right[i*W +: W]  = v.mask[i] ? v.r : '0;
            rect_bottom[i*W +: W] = v.mask[i] ? v.b : '0;
        end
        coord_x = v.x;
        coord_y = v.y;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vectors++;
        if (got !== want) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    logic exp_stream[16];
    vec_t stream_cfg;

    initial begin
        reset_n = 1'b0;
        coord_x = '0;
        coord_y = '0;
        rect_left = '0; rect_top = '0; rect_right = '0; rect_bottom = '0;

        vecs[0]  = mk(64'h20, 10, 20, 30, 40, 9, 25, 0, 0, 64'h0);
        vecs[1]  = mk(64'h20, 10, 20, 30, 40, 10, 25, 1, 5, 64'h20);
        vecs[2]  = mk(64'h20, 10, 20, 30, 40, 29, 25, 1, 5, 64'h20);
        vecs[3]  = mk(64'h20, 10, 20, 30, 40, 30, 25, 0, 0, 64'h0);
        vecs[4]  = mk(64'h20, 10, 20, 30, 40, 10, 19, 0, 0, 64'h0);
        vecs[5]  = mk(64'h20, 10, 20, 30, 40, 10, 39, 1, 5, 64'h20);
        vecs[6]  = mk(64'h20, 10, 20, 30, 40, 10, 40, 0, 0, 64'h0);
        vecs[7]  = mk(64'h8000_0000_0002_0008, 90, 90, 110, 110, 100, 100, 1, 63, 64'h8000_0000_0002_0008);
        vecs[8]  = mk(64'h0000_0000_0002_0008, 90, 90, 110, 110, 100, 100, 1, 17, 64'h0000_0000_0002_0008);
        vecs[9]  = mk(64'h1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0);
        vecs[10] = mk(64'h2, 50, 0, 40, 100, 45, 10, 0, 0, 64'h0);
        vecs[11] = mk(64'h4, 16'hFFFE, 0, 16'hFFFF, 100, 16'hFFFE, 5, 1, 2, 64'h4);
        vecs[12] = mk(64'h4, 16'hFFFE, 0, 16'hFFFF, 100, 16'hFFFF, 5, 0, 0, 64'h0);
        vecs[13] = mk(64'hFFFF_FFFF_FFFF_FFFF, 190, 190, 210, 210, 200, 200, 1, 63, 64'hFFFF_FFFF_FFFF_FFFF);
        vecs[14] = mk(64'h1, 0, 0, 5, 5, 2, 2, 1, 0, 64'h1);
        vecs[15] = mk(64'h0000_0300_0040_0000, 290, 290, 310, 310, 300, 300, 1, 41, 64'h0000_0300_0040_0000);
        vecs[16] = mk(64'h50, 290, 290, 310, 310, 300, 300, 1, 6, 64'h50);
        vecs[17] = mk(64'h1_8000, 290, 290, 310, 310, 300, 300, 1, 16, 64'h1_8000);
        vecs[18] = mk(64'h0000_8000_0000_0000, 290, 290, 310, 310, 300, 300, 1, 47, 64'h0000_8000_0000_0000);
        vecs[19] = mk(64'h7FFF_FFFF_FFFF_FFFF, 190, 190, 210, 210, 200, 200, 1, 62, 64'h7FFF_FFFF_FFFF_FFFF);

        #12;
        checkOutput("reset collisions", collisions, 64'h0);
        checkOutput("reset hit", 64'(hit), 64'h0);
        checkOutput("reset rect_idx", 64'(rect_idx), 64'h0);
        @(negedge pixel_clk);
        reset_n = 1'b1;
        step();

        // Each vector is held three edges so it fully drains through the pipe.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i]);
            step();
            step();
            checkOutput($sformatf("vec%0d collisions", i), collisions, vecs[i].exp_coll);
            step();
            checkOutput($sformatf("vec%0d hit", i), 64'(hit), 64'(vecs[i].exp_hit));
            checkOutput($sformatf("vec%0d rect_idx", i), 64'(rect_idx), 64'(vecs[i].exp_idx));
        end

        // Streaming: rect 7 covers x in [10,20), y in [10,20); alternate hit/miss.
        stream_cfg = mk(64'h80, 10, 10, 20, 20, 0, 15, 0, 0, 64'h0);
        applyStimulus(stream_cfg);
        for (int c = 0; c < 10; c++) begin
            exp_stream[c] = (c % 2) == 0;
            coord_x = exp_stream[c] ? W'(15) : W'(25);
            step();
            if (c >= 1)
                checkOutput($sformatf("stream%0d coll7", c), 64'(collisions[7]), 64'(exp_stream[c-1]));
            if (c >= 2) begin
                checkOutput($sformatf("stream%0d hit", c), 64'(hit), 64'(exp_stream[c-2]));
                checkOutput($sformatf("stream%0d rect_idx", c), 64'(rect_idx),
                            exp_stream[c-2] ? 64'd7 : 64'd0);
            end
        end

        // Short asynchronous reset pulse between edges, mid-stream.
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midreset collisions", collisions, 64'h0);
        checkOutput("midreset hit", 64'(hit), 64'h0);
        checkOutput("midreset rect_idx", 64'(rect_idx), 64'h0);
        #2;
        reset_n = 1'b1;

        for (int c = 0; c < 8; c++) begin
            exp_stream[c] = (c % 2) == 1;
            coord_x = exp_stream[c] ? W'(15) : W'(25);
            step();
            checkOutput($sformatf("post%0d coll7", c), 64'(collisions[7]),
                        c >= 1 ? 64'(exp_stream[c-1]) : 64'h0);
            checkOutput($sformatf("post%0d hit", c), 64'(hit),
                        c >= 2 ? 64'(exp_stream[c-2]) : 64'h0);
            checkOutput($sformatf("post%0d rect_idx", c), 64'(rect_idx),
                        (c >= 2 && exp_stream[c-2]) ? 64'd7 : 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
